// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one request/grant/response memory bus
// between a CPU core's fetch port and data port, with a response timeout.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_done,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,
  input  logic                d_req,
  input  logic                d_wen,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_req,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int          MASK_W   = DATA_W / 8;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, I_REQ, D_REQ, I_WAIT, D_WAIT} state_t;

  state_t              state_q, state_d;
  logic                last_d_q, last_d_d;  // 1 = data port was granted last
  logic [15:0]         cnt_q, cnt_d;
  logic                mem_req_d, mem_wen_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_d;
  logic [MASK_W-1:0]   mem_wmask_d;
  logic                i_done_d, i_err_d, d_done_d, d_err_d;
  logic [DATA_W-1:0]   i_rdata_d, d_rdata_d;
  logic                i_ok, d_ok, grant_i, grant_d;

  // A port whose done is pulsing this cycle is not re-sampled.
  assign i_ok    = i_req & ~i_done;
  assign d_ok    = d_req & ~d_done;
  assign grant_i = i_ok & (~d_ok | last_d_q);
  assign grant_d = d_ok & ~grant_i;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    last_d_d    = last_d_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req;
    mem_wen_d   = mem_wen;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_wmask_d = mem_wmask;
    i_done_d    = 1'b0;
    i_err_d     = 1'b0;
    i_rdata_d   = i_rdata;
    d_done_d    = 1'b0;
    d_err_d     = 1'b0;
    d_rdata_d   = d_rdata;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d     = I_REQ;
          last_d_d    = 1'b0;
          mem_req_d   = 1'b1;
          mem_wen_d   = 1'b0;
          mem_addr_d  = i_addr;
          mem_wdata_d = '0;
          mem_wmask_d = '0;
        end else if (grant_d) begin
          state_d     = D_REQ;
          last_d_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_wen_d   = d_wen;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_wmask_d = d_wen ? d_wmask : '0;
        end
      end
      I_REQ, D_REQ: begin
        if (mem_gnt) begin
          state_d   = (state_q == I_REQ) ? I_WAIT : D_WAIT;
          mem_req_d = 1'b0;
          cnt_d     = '0;
        end
      end
      I_WAIT: begin
        if (mem_rvalid) begin
          state_d   = IDLE;
          i_done_d  = 1'b1;
          i_rdata_d = mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          i_done_d  = 1'b1;
          i_err_d   = 1'b1;
          i_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      D_WAIT: begin
        if (mem_rvalid) begin
          state_d   = IDLE;
          d_done_d  = 1'b1;
          d_rdata_d = mem_wen ? '0 : mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          d_done_d  = 1'b1;
          d_err_d   = 1'b1;
          d_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b1;
      cnt_q     <= '0;
      mem_req   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      i_done    <= 1'b0;
      i_err     <= 1'b0;
      i_rdata   <= '0;
      d_done    <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      cnt_q     <= cnt_d;
      mem_req   <= mem_req_d;
      mem_wen   <= mem_wen_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_wmask <= mem_wmask_d;
      i_done    <= i_done_d;
      i_err     <= i_err_d;
      i_rdata   <= i_rdata_d;
      d_done    <= d_done_d;
      d_err     <= d_err_d;
      d_rdata   <= d_rdata_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_done, i_err;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          d_req, d_wen, d_done, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic [MW-1:0] d_wmask;
  logic          mem_req, mem_wen, mem_gnt, mem_rvalid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [MW-1:0] mem_wmask;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the bus, whether memory accepted,
  // how many cycles spent waiting, and which port was served last.
  int            m_owner;   // 0 none, 1 fetch, 2 data
  bit            m_acc, m_last_d, m_store;
  int            m_waited, pick;
  bit            blk_i, blk_d, want_i, want_d;
  logic          e_mem_req, e_mem_wen, e_i_done, e_i_err, e_d_done, e_d_err;
  logic [AW-1:0] e_mem_addr;
  logic [DW-1:0] e_mem_wdata, e_i_rdata, e_d_rdata;
  logic [MW-1:0] e_mem_wmask;

  task automatic model_finish(input bit timed_out);
    if (m_owner == 1) begin
      e_i_done  = 1'b1;
      e_i_err   = timed_out;
      e_i_rdata = timed_out ? '0 : mem_rdata;
    end else begin
      e_d_done  = 1'b1;
      e_d_err   = timed_out;
      e_d_rdata = (timed_out || m_store) ? '0 : mem_rdata;
    end
    m_owner = 0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_owner = 0; m_acc = 0; m_waited = 0; m_last_d = 1; m_store = 0;
      e_mem_req = 0; e_mem_wen = 0; e_mem_addr = '0; e_mem_wdata = '0; e_mem_wmask = '0;
      e_i_done = 0; e_i_err = 0; e_i_rdata = '0;
      e_d_done = 0; e_d_err = 0; e_d_rdata = '0;
    end else begin
      blk_i = e_i_done;
      blk_d = e_d_done;
      e_i_done = 0; e_d_done = 0; e_i_err = 0; e_d_err = 0;
      if (m_owner == 0) begin
        want_i = i_req && !blk_i;
        want_d = d_req && !blk_d;
        pick = 0;
        if (want_i && want_d) pick = m_last_d ? 1 : 2;
        else if (want_i)      pick = 1;
        else if (want_d)      pick = 2;
        if (pick == 1) begin
          e_mem_addr = i_addr; e_mem_wen = 0; e_mem_wmask = '0;
        end else if (pick == 2) begin
          e_mem_addr = d_addr; e_mem_wen = d_wen; e_mem_wdata = d_wdata;
          e_mem_wmask = d_wen ? d_wmask : '0;
        end
        if (pick != 0) begin
          m_owner = pick; m_acc = 0; m_last_d = (pick == 2);
          m_store = (pick == 2) && d_wen; e_mem_req = 1;
        end
      end else if (!m_acc) begin
        if (mem_gnt) begin
          m_acc = 1; m_waited = 0; e_mem_req = 0;
        end
      end else begin
        m_waited++;
        if (mem_rvalid)          model_finish(1'b0);
        else if (m_waited >= TO) model_finish(1'b1);
      end
    end
  end

  always @(negedge clk) begin
    check("cmp mem_req", mem_req, e_mem_req);
    check("cmp i_done", i_done, e_i_done);
    check("cmp i_err", i_err, e_i_err);
    check("cmp i_rdata", i_rdata, e_i_rdata);
    check("cmp d_done", d_done, e_d_done);
    check("cmp d_err", d_err, e_d_err);
    check("cmp d_rdata", d_rdata, e_d_rdata);
    if (e_mem_req) begin
      check("cmp mem_addr", mem_addr, e_mem_addr);
      check("cmp mem_wen", mem_wen, e_mem_wen);
      check("cmp mem_wmask", mem_wmask, e_mem_wmask);
      if (m_owner == 2) check("cmp mem_wdata", mem_wdata, e_mem_wdata);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, " mem_req"}, mem_req, 0);
    check({tag, " mem_wen"}, mem_wen, 0);
    check({tag, " mem_addr"}, mem_addr, 0);
    check({tag, " mem_wdata"}, mem_wdata, 0);
    check({tag, " mem_wmask"}, mem_wmask, 0);
    check({tag, " i_done"}, i_done, 0);
    check({tag, " d_done"}, d_done, 0);
    check({tag, " i_err"}, i_err, 0);
    check({tag, " d_err"}, d_err, 0);
    check({tag, " i_rdata"}, i_rdata, 0);
    check({tag, " d_rdata"}, d_rdata, 0);
  endtask

  // Waits for mem_req, checks the request fields on every REQ cycle, grants
  // after gnt_delay cycles, responds one cycle later. Returns in the done cycle.
  task automatic serve(input logic [AW-1:0] x_addr, input logic x_wen,
                       input logic [DW-1:0] x_wdata, input bit chk_wd,
                       input logic [MW-1:0] x_wmask, input int gnt_delay,
                       input logic [DW-1:0] rdata, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_req && lat < 20);
    if (!mem_req) begin
      check("serve mem_req seen", mem_req, 1);
      return;
    end
    for (int k = 0; k <= gnt_delay; k++) begin
      if (k > 0) @(negedge clk);
      check("req mem_req", mem_req, 1);
      check("req mem_addr", mem_addr, x_addr);
      check("req mem_wen", mem_wen, x_wen);
      check("req mem_wmask", mem_wmask, x_wmask);
      if (chk_wd) check("req mem_wdata", mem_wdata, x_wdata);
    end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("gnt drops mem_req", mem_req, 0);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    i_req = 0; i_addr = '0; d_req = 0; d_wen = 0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Single fetch, best-case latency.
    i_addr = 32'h8000_0000; i_req = 1;
    serve(32'h8000_0000, 1'b0, '0, 1'b0, 4'h0, 0, 32'h0000_0413, lat);
    check("fetch req latency", lat, 1);
    check("fetch i_done", i_done, 1);
    check("fetch i_rdata", i_rdata, 32'h0000_0413);
    check("fetch i_err", i_err, 0);
    i_req = 0;
    @(negedge clk);
    check("fetch done one pulse", i_done, 0);
    check("fetch rdata held", i_rdata, 32'h0000_0413);

    // Store: rdata must read 0 despite nonzero bus data.
    d_wen = 1; d_addr = 32'h8000_1004; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'h3; d_req = 1;
    serve(32'h8000_1004, 1'b1, 32'hDEAD_BEEF, 1'b1, 4'h3, 0, 32'h1234_5678, lat);
    check("store d_done", d_done, 1);
    check("store d_rdata", d_rdata, 0);
    check("store d_err", d_err, 0);
    check("store no i_done", i_done, 0);
    d_req = 0; d_wen = 0;
    @(negedge clk);
    check("store done one pulse", d_done, 0);

    // Grant withheld 5 cycles: fields stable for 6 REQ cycles.
    i_addr = 32'h8000_0100; i_req = 1;
    serve(32'h8000_0100, 1'b0, '0, 1'b0, 4'h0, 5, 32'hCAFE_0001, lat);
    check("stall i_done", i_done, 1);
    check("stall i_rdata", i_rdata, 32'hCAFE_0001);
    i_req = 0;
    @(negedge clk);

    // Timeout on a load; wmask forced to 0 on reads.
    d_wen = 0; d_addr = 32'h8000_2000; d_wmask = 4'hF; d_req = 1;
    @(negedge clk);
    check("to mem_req", mem_req, 1);
    check("to mem_wmask", mem_wmask, 4'h0);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    for (int c = 0; c < TO; c++) begin
      check("to early d_done", d_done, 0);
      @(negedge clk);
    end
    check("to d_done", d_done, 1);
    check("to d_err", d_err, 1);
    check("to d_rdata", d_rdata, 0);
    d_req = 0;
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
    check("stray pre d_done", d_done, 0);
    @(negedge clk);
    mem_rvalid = 0; mem_rdata = '0;
    check("stray d_done", d_done, 0);
    check("stray i_done", i_done, 0);
    @(negedge clk);
    check("stray later d_done", d_done, 0);

    // Reset during I_WAIT, then contention from release.
    i_addr = 32'h0000_3000; i_req = 1;
    @(negedge clk);
    check("rst-mid mem_req", mem_req, 1);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    d_wen = 0; d_addr = 32'h0000_2000; d_wdata = '0; d_wmask = '0; d_req = 1;
    i_addr = 32'h0000_1000;
    #2 rst = 1'b0;
    #1 check_all_zero("mid reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int t = 0; t < 2; t++) begin
      serve(32'h0000_1000, 1'b0, '0, 1'b0, 4'h0, 0, 32'hA0 + DW'(t), lat);
      check("rr fetch i_done", i_done, 1);
      check("rr fetch i_rdata", i_rdata, 32'hA0 + DW'(t));
      check("rr fetch no d_done", d_done, 0);
      serve(32'h0000_2000, 1'b0, '0, 1'b1, 4'h0, 0, 32'hB0 + DW'(t), lat);
      check("rr data d_done", d_done, 1);
      check("rr data d_rdata", d_rdata, 32'hB0 + DW'(t));
      check("rr data no i_done", i_done, 0);
    end
    i_req = 0; d_req = 0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
